// File: rtl/ahb_cache_bridge_pkg.sv
// ahb_cache_bridge_pkg: shared types and AHB constants for the AHB-to-cache bridge.
// Contents: bridge FSM state encoding, HTRANS/HSIZE/HRESP codes.
package ahb_cache_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_mask_gen.sv
// ahb_mask_gen: byte-lane mask and alignment flag for an AHB transfer.
// Ports: i_hsize (transfer size), i_addr_lo (haddr[1:0]) -> o_mask (byte enables),
//        o_misaligned (half on odd byte, word off word boundary, or size above word).
module ahb_mask_gen
    import ahb_cache_bridge_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_mask,
    output logic       o_misaligned
);

    always_comb begin
        o_mask = (i_hsize == HSIZE_BYTE) ? 4'b0001 << i_addr_lo :
                 (i_hsize == HSIZE_HALF) ? 4'b0011 << {i_addr_lo[1], 1'b0} : 4'b1111;
        o_misaligned = ((i_hsize == HSIZE_HALF) & i_addr_lo[0]) |
                       ((i_hsize == HSIZE_WORD) & (i_addr_lo != 2'b00)) |
                       (i_hsize > HSIZE_WORD);
    end

endmodule

// File: rtl/ahb_cache_bridge.sv
// ahb_cache_bridge: AHB5-Lite slave turning pipelined transfers into single-cycle cache requests.
// Ports: clk, rst_x (async, active-low); AHB slave i_hsel/i_haddr/i_htrans/i_hwrite/i_hsize/
//        i_hready/i_hwdata -> o_hready_resp/o_hresp/o_hrdata; cache side o_c_rd_en/o_c_wr_en/
//        o_c_addr/o_c_wdata/o_c_mask, i_c_rdata/i_c_busy.
// Build option: BRIDGE_ALIGN_CHECK_EN answers misaligned or oversized transfers with a
//        two-cycle ERROR and no cache request; without it alignment is not checked.
module ahb_cache_bridge
    import ahb_cache_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 23,
    parameter int AHB_AW     = 32
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              i_hsel,
    input  logic [AHB_AW-1:0] i_haddr,
    input  logic [1:0]        i_htrans,
    input  logic              i_hwrite,
    input  logic [2:0]        i_hsize,
    input  logic              i_hready,
    input  logic [31:0]       i_hwdata,
    output logic              o_hready_resp,
    output logic              o_hresp,
    output logic [31:0]       o_hrdata,
    output logic              o_c_rd_en,
    output logic              o_c_wr_en,
    output logic [31:0]       o_c_addr,
    output logic [31:0]       o_c_wdata,
    output logic [3:0]        o_c_mask,
    input  logic [31:0]       i_c_rdata,
    input  logic              i_c_busy
);

    state_t      r_state, w_next, w_acc_state, w_done;
    logic [31:0] r_addr, w_addr;
    logic [3:0]  r_mask, w_mask;
    logic        w_misaligned, w_err, w_req, w_take, w_unused_bits;

    ahb_mask_gen u_mask (
        .i_hsize     (i_hsize),
        .i_addr_lo   (i_haddr[1:0]),
        .o_mask      (w_mask),
        .o_misaligned(w_misaligned)
    );

`ifdef BRIDGE_ALIGN_CHECK_EN
    assign w_err = w_misaligned;
`else
    assign w_err = 1'b0;
`endif

    // haddr bits above ADDR_WIDTH are intentionally dropped
    assign w_unused_bits = ^{w_misaligned, i_haddr};

    always_comb begin
        w_addr = '0;
        w_addr[ADDR_WIDTH-1:2] = i_haddr[ADDR_WIDTH-1:2];
    end

    // An address phase is only taken in a cycle where this slave itself is ready,
    // so a new transfer overlaps the completing data phase of the previous one.
    assign w_req       = i_hsel & i_hready & ((i_htrans == HTRANS_NONSEQ) | (i_htrans == HTRANS_SEQ));
    assign w_take      = w_req & o_hready_resp;
    assign w_acc_state = w_err ? S_ERR1 : i_hwrite ? S_WR_ISSUE : S_RD_ISSUE;
    assign w_done      = w_take ? w_acc_state : S_IDLE;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Request address and mask hold from ISSUE through completion.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_addr <= '0;
            r_mask <= '0;
        end else if (w_take & !w_err) begin
            r_addr <= w_addr;
            r_mask <= w_mask;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_ERR2:       w_next = w_done;
            S_RD_ISSUE:           w_next = i_c_busy ? S_RD_ISSUE : S_RD_WAIT;
            S_WR_ISSUE:           w_next = i_c_busy ? S_WR_ISSUE : S_WR_WAIT;
            S_RD_WAIT, S_WR_WAIT: w_next = i_c_busy ? r_state : w_done;
            S_ERR1:               w_next = S_ERR2;
            default:              w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_hready_resp = (r_state == S_IDLE) | (r_state == S_ERR2) |
                        (((r_state == S_RD_WAIT) | (r_state == S_WR_WAIT)) & !i_c_busy);
        o_hresp       = ((r_state == S_ERR1) | (r_state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        o_c_rd_en     = (r_state == S_RD_ISSUE) & !i_c_busy;
        o_c_wr_en     = (r_state == S_WR_ISSUE) & !i_c_busy;
        o_hrdata      = ((r_state == S_RD_WAIT) & !i_c_busy) ? i_c_rdata : '0;
    end

    assign o_c_addr  = r_addr;
    assign o_c_mask  = r_mask;
    assign o_c_wdata = i_hwdata;

endmodule

// File: tb/tb_ahb_cache_bridge.sv
// tb_ahb_cache_bridge: scoreboard bench for ahb_cache_bridge with a behavioural cache model.
module tb_ahb_cache_bridge;

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          pre;
        logic [31:0] e_addr;
        logic [3:0]  e_mask;
        int          e_waits;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        wr;
        logic        err;
        int          waits;
        logic [31:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [31:0] hwdata = '0;
    logic        c_busy = 1'b0;
    logic [31:0] rd_cur = '0;
    int          lat_cur = 0;
    int          busy_cnt = 0;

    logic        hready_resp, hresp, c_rd_en, c_wr_en;
    logic [31:0] hrdata, c_addr, c_wdata, c_rdata;
    logic [3:0]  c_mask;

    vec_t  vec[16];
    req_t  req_q[$];
    resp_t resp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    assign c_rdata = c_busy ? 32'hBAD0_BAD0 : rd_cur;

    always #5 clk = ~clk;

    ahb_cache_bridge dut (
        .clk          (clk),
        .rst_x        (rst_x),
        .i_hsel       (hsel),
        .i_haddr      (haddr),
        .i_htrans     (htrans),
        .i_hwrite     (hwrite),
        .i_hsize      (hsize),
        .i_hready     (hready_resp),
        .i_hwdata     (hwdata),
        .o_hready_resp(hready_resp),
        .o_hresp      (hresp),
        .o_hrdata     (hrdata),
        .o_c_rd_en    (c_rd_en),
        .o_c_wr_en    (c_wr_en),
        .o_c_addr     (c_addr),
        .o_c_wdata    (c_wdata),
        .o_c_mask     (c_mask),
        .i_c_rdata    (c_rdata),
        .i_c_busy     (c_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load();
        vec[0]  = '{1'b1, 2'b10, 1'b0, 32'h100, 3'd2, 32'h0, 32'hDEADBEEF, 0, 0, 32'h100, 4'hF, 1, 1'b0};
        vec[1]  = '{1'b1, 2'b10, 1'b1, 32'h103, 3'd0, 32'hAA000000, 32'h0, 5, 0, 32'h100, 4'b1000, 6, 1'b0};
        vec[2]  = '{1'b1, 2'b10, 1'b0, 32'h200, 3'd2, 32'h0, 32'h12345678, 20, 0, 32'h200, 4'hF, 21, 1'b0};
        vec[3]  = '{1'b1, 2'b10, 1'b1, 32'h010, 3'd2, 32'hCAFEF00D, 32'h0, 2, 0, 32'h010, 4'hF, 3, 1'b0};
        vec[4]  = '{1'b1, 2'b11, 1'b0, 32'h010, 3'd2, 32'h0, 32'hCAFEF00D, 0, 0, 32'h010, 4'hF, 1, 1'b0};
        vec[5]  = '{1'b1, 2'b10, 1'b0, 32'h022, 3'd1, 32'h0, 32'h55660000, 1, 0, 32'h020, 4'b1100, 2, 1'b0};
        vec[6]  = '{1'b1, 2'b10, 1'b1, 32'h020, 3'd1, 32'h0000BEEF, 32'h0, 0, 0, 32'h020, 4'b0011, 1, 1'b0};
        vec[7]  = '{1'b1, 2'b10, 1'b0, 32'h401, 3'd0, 32'h0, 32'h0000A500, 0, 0, 32'h400, 4'b0010, 1, 1'b0};
        vec[8]  = '{1'b1, 2'b00, 1'b0, 32'h900, 3'd2, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 1'b0};
        vec[9]  = '{1'b0, 2'b10, 1'b0, 32'h500, 3'd2, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 1'b0};
        vec[10] = '{1'b1, 2'b10, 1'b0, 32'hFF800104, 3'd2, 32'h0, 32'h13579BDF, 0, 0, 32'h104, 4'hF, 1, 1'b0};
`ifdef BRIDGE_ALIGN_CHECK_EN
        vec[11] = '{1'b1, 2'b10, 1'b0, 32'h102, 3'd2, 32'h0, 32'h0A0B0C0D, 0, 0, 32'h0, 4'h0, 1, 1'b1};
        vec[12] = '{1'b1, 2'b10, 1'b1, 32'h021, 3'd1, 32'h00002100, 32'h0, 0, 0, 32'h0, 4'h0, 1, 1'b1};
`else
        vec[11] = '{1'b1, 2'b10, 1'b0, 32'h102, 3'd2, 32'h0, 32'h0A0B0C0D, 0, 0, 32'h100, 4'hF, 1, 1'b0};
        vec[12] = '{1'b1, 2'b10, 1'b1, 32'h021, 3'd1, 32'h00002100, 32'h0, 0, 0, 32'h020, 4'b0011, 1, 1'b0};
`endif
        vec[13] = '{1'b1, 2'b10, 1'b0, 32'h600, 3'd2, 32'h0, 32'h600D600D, 1, 3, 32'h600, 4'hF, 4, 1'b0};
        vec[14] = '{1'b1, 2'b10, 1'b1, 32'h080, 3'd2, 32'h11223344, 32'h0, 10, 0, 32'h080, 4'hF, 0, 1'b0};
        vec[15] = '{1'b1, 2'b10, 1'b0, 32'h044, 3'd2, 32'h0, 32'h4444AAAA, 0, 0, 32'h044, 4'hF, 1, 1'b0};
    endtask

    task automatic drive_ap(input int idx);
        if (idx < 0) begin
            hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = '0;
        end else begin
            hsel = vec[idx].sel; htrans = vec[idx].tr; haddr = vec[idx].addr;
            hwrite = vec[idx].wr; hsize = vec[idx].size;
            if (vec[idx].sel && vec[idx].tr[1]) begin
                resp_q.push_back('{vec[idx].wr, vec[idx].e_err, vec[idx].e_waits, vec[idx].rdata});
                if (!vec[idx].e_err)
                    req_q.push_back('{vec[idx].wr, vec[idx].e_addr, vec[idx].e_mask, vec[idx].wdata});
            end
        end
    endtask

    task automatic run(input int first, input int last);
        int   ap, dp, cyc;
        logic rdy;
        ap = first;
        cyc = 0;
        drive_ap(ap);
        if (vec[first].pre > 0) begin
            #1;
            busy_cnt = vec[first].pre;
            c_busy = 1'b1;
        end
        forever begin
            @(negedge clk);
            rdy = hready_resp;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) begin
                dp = (ap <= last) ? ap : -1;
                if (dp < 0) break;
                hwdata = vec[dp].wr ? vec[dp].wdata : 32'h0;
                lat_cur = vec[dp].lat;
                rd_cur = vec[dp].rdata;
                ap++;
                drive_ap(ap <= last ? ap : -1);
            end
            if (cyc > 200) begin
                chk("run_timeout", 32'(cyc), 32'd200);
                break;
            end
        end
        hwdata = '0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_hready_resp"}, 32'(hready_resp), 32'd1);
        chk({tag, "_hresp"}, 32'(hresp), 32'd0);
        chk({tag, "_hrdata"}, hrdata, 32'd0);
        chk({tag, "_c_rd_en"}, 32'(c_rd_en), 32'd0);
        chk({tag, "_c_wr_en"}, 32'(c_wr_en), 32'd0);
        chk({tag, "_c_addr"}, c_addr, 32'd0);
        chk({tag, "_c_mask"}, 32'(c_mask), 32'd0);
    endtask

    // Cache model: busy for the current transfer's latency after each request.
    initial begin
        logic saw;
        forever begin
            @(negedge clk);
            saw = c_rd_en | c_wr_en;
            @(posedge clk);
            #1;
            busy_cnt = saw ? lat_cur : (busy_cnt > 0 ? busy_cnt - 1 : 0);
            c_busy = busy_cnt > 0;
        end
    end

    // Monitor: pops expected cache requests and AHB completions as the DUT presents them.
    initial begin
        logic  pend;
        int    waits;
        req_t  q;
        resp_t r;
        pend = 1'b0;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!rst_x) begin
                pend = 1'b0;
                waits = 0;
            end else begin
                if (c_rd_en | c_wr_en) begin
                    chk("rd_wr_exclusive", 32'(c_rd_en & c_wr_en), 32'd0);
                    if (req_q.size() == 0) chk("stray_request", 32'({c_rd_en, c_wr_en}), 32'd0);
                    else begin
                        q = req_q.pop_front();
                        chk("req_write", 32'(c_wr_en), 32'(q.wr));
                        chk("req_addr", c_addr, q.addr);
                        chk("req_mask", 32'(c_mask), 32'(q.mask));
                        if (q.wr) chk("req_wdata", c_wdata, q.wdata);
                    end
                end
                if (pend) begin
                    if (resp_q.size() == 0) begin
                        chk("resp_orphan", 32'(resp_q.size()), 32'd1);
                        pend = 1'b0;
                    end else if (hready_resp) begin
                        r = resp_q.pop_front();
                        chk("wait_states", 32'(waits), 32'(r.waits));
                        chk("hresp", 32'(hresp), 32'(r.err));
                        if (!r.wr && !r.err) chk("hrdata", hrdata, r.rdata);
                        pend = 1'b0;
                        waits = 0;
                    end else begin
                        waits++;
                        chk("stall_hresp", 32'(hresp), 32'(resp_q[0].err));
                    end
                end else begin
                    chk("idle_ready", 32'(hready_resp), 32'd1);
                    chk("idle_hresp", 32'(hresp), 32'd0);
                end
                if (hready_resp) pend = hsel & htrans[1];
            end
        end
    end

    initial begin
        load();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        rst_x = 1'b1;
        @(posedge clk);
        #1;
        run(0, 12);
        repeat (2) @(posedge clk);
        #1;
        run(13, 13);
        @(posedge clk);
        #1;
        drive_ap(14);
        @(negedge clk);
        @(posedge clk);
        #1;
        hwdata = vec[14].wdata;
        lat_cur = vec[14].lat;
        drive_ap(-1);
        repeat (2) @(negedge clk);
        #3 rst_x = 1'b0;
        #1 reset_checks("wr_wait_rst");
        resp_q.delete();
        busy_cnt = 0;
        c_busy = 1'b0;
        hwdata = '0;
        repeat (2) @(negedge clk);
        #3 rst_x = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run(15, 15);
        repeat (2) @(posedge clk);
        #1;
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
